// File: rtl/ecg_parse_sched.sv
// ECG parse scheduler: packs 32-bit bitstream words into an MSB-aligned bit
// buffer and feeds a 128-bit window to the combinational ECG parser, one ECG per cycle.
module ecg_parse_sched #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned BUF_W   = 256,
   parameter int unsigned MAX_ECG = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode_xfm,
   input  logic [2:0]   num_ecg,
   input  logic [11:0]  ns_cfg,
   input  logic         flush,
   input  logic [31:0]  bs_data,
   input  logic         bs_valid,
   output logic         bs_ready,
   output logic [127:0] win_data,
   output logic         win_valid,
   output logic [1:0]   win_ecg_idx,
   output logic [2:0]   win_num_sample,
   output logic         win_mode_xfm,
   input  logic [7:0]   ecg_numbits,
   output logic         ecg_done,
   output logic         blk_done,
   output logic         busy,
   output logic         err,
   output logic [15:0]  bits_used
);

   localparam int unsigned WIN_W  = 128;
   localparam int unsigned FILL_W = $clog2(BUF_W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PARSE, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [BUF_W-1:0]    bitbuf_q, bitbuf_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [1:0]          ecg_cnt_q, ecg_cnt_d;
   logic [1:0]          last_idx_q, last_idx_d;
   logic [11:0]         ns_q, ns_d;
   logic                mode_q, mode_d;
   logic                err_q, err_d;
   logic [15:0]         bits_used_q, bits_used_d;
   logic                ecg_done_q, ecg_done_d;

   logic                win_ok, nb_bad, consume, push, flushing;
   logic [FILL_W-1:0]   nb_ext, cons, avail, base_fill;
   logic [BUF_W-1:0]    base_buf, word_ext;
   logic [16:0]         used_sum;

   always_comb begin
      nb_ext   = FILL_W'(ecg_numbits);
      win_ok   = (state_q == ST_PARSE) && (fill_q >= FILL_W'(WIN_W));
      nb_bad   = (ecg_numbits == 8'd0) || (nb_ext > fill_q);
      consume  = win_ok && !nb_bad;
      cons     = consume ? nb_ext : '0;
      avail    = fill_q - cons;
      bs_ready = avail <= FILL_W'(BUF_W - WORD_W);
      push     = bs_valid && bs_ready;
      flushing = flush && (state_q == ST_IDLE);

      // Consume and push land in one update: shift first, then place the
      // new word directly below the bits that remain.
      base_buf  = flushing ? '0 : (bitbuf_q << cons);
      base_fill = flushing ? '0 : avail;
      word_ext  = {bs_data, {(BUF_W - WORD_W){1'b0}}};
      bitbuf_d  = push ? (base_buf | (word_ext >> base_fill)) : base_buf;
      fill_d    = base_fill + (push ? FILL_W'(WORD_W) : '0);
   end

   always_comb begin
      state_d     = state_q;
      ecg_cnt_d   = ecg_cnt_q;
      last_idx_d  = last_idx_q;
      ns_d        = ns_q;
      mode_d      = mode_q;
      err_d       = err_q;
      bits_used_d = bits_used_q;
      ecg_done_d  = 1'b0;
      used_sum    = {1'b0, bits_used_q} + 17'(ecg_numbits);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d      = mode_xfm;
               ns_d        = ns_cfg;
               err_d       = 1'b0;
               bits_used_d = '0;
               ecg_cnt_d   = '0;
               state_d     = ST_PARSE;
               if (num_ecg == 3'd0)
                  last_idx_d = '0;
               else if (num_ecg > 3'(MAX_ECG))
                  last_idx_d = 2'(MAX_ECG - 1);
               else
                  last_idx_d = 2'(num_ecg - 3'd1);
            end
         end
         ST_PARSE: begin
            if (win_ok) begin
               if (nb_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ecg_done_d  = 1'b1;
                  bits_used_d = used_sum[16] ? 16'hFFFF : used_sum[15:0];
                  // Index holds on the last ECG so it still names it during DONE.
                  if (ecg_cnt_q == last_idx_q)
                     state_d = ST_DONE;
                  else
                     ecg_cnt_d = ecg_cnt_q + 2'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bitbuf_q    <= '0;
         fill_q      <= '0;
         ecg_cnt_q   <= '0;
         last_idx_q  <= '0;
         ns_q        <= '0;
         mode_q      <= 1'b0;
         err_q       <= 1'b0;
         bits_used_q <= '0;
         ecg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitbuf_q    <= bitbuf_d;
         fill_q      <= fill_d;
         ecg_cnt_q   <= ecg_cnt_d;
         last_idx_q  <= last_idx_d;
         ns_q        <= ns_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
         bits_used_q <= bits_used_d;
         ecg_done_q  <= ecg_done_d;
      end
   end

   assign win_data       = bitbuf_q[BUF_W-1 -: WIN_W];
   assign win_valid      = win_ok;
   assign win_ecg_idx    = ecg_cnt_q;
   assign win_num_sample = ns_q[ecg_cnt_q*3 +: 3];
   assign win_mode_xfm   = mode_q;
   assign ecg_done       = ecg_done_q;
   assign blk_done       = (state_q == ST_DONE);
   assign busy           = (state_q != ST_IDLE);
   assign err            = err_q;
   assign bits_used      = bits_used_q;

endmodule

// File: tb/tb_ecg_parse_sched.sv
// Bench for ecg_parse_sched: cycle table, directed corner sequences, then random
// traffic against a bit-queue reference model of the buffer and block sequencing.
module tb_ecg_parse_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, mode_xfm, flush, bs_valid;
   logic [2:0]   num_ecg;
   logic [11:0]  ns_cfg;
   logic [31:0]  bs_data;
   logic [7:0]   ecg_numbits;
   logic         bs_ready, win_valid, win_mode_xfm, ecg_done, blk_done, busy, err;
   logic [127:0] win_data;
   logic [1:0]   win_ecg_idx;
   logic [2:0]   win_num_sample;
   logic [15:0]  bits_used;

   always #5 clk = ~clk;

   ecg_parse_sched #(.WORD_W(32), .BUF_W(256), .MAX_ECG(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_xfm(mode_xfm), .num_ecg(num_ecg),
      .ns_cfg(ns_cfg), .flush(flush), .bs_data(bs_data), .bs_valid(bs_valid),
      .bs_ready(bs_ready), .win_data(win_data), .win_valid(win_valid),
      .win_ecg_idx(win_ecg_idx), .win_num_sample(win_num_sample),
      .win_mode_xfm(win_mode_xfm), .ecg_numbits(ecg_numbits), .ecg_done(ecg_done),
      .blk_done(blk_done), .busy(busy), .err(err), .bits_used(bits_used)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: buffer is a queue of bits, front = next unread bit.
   typedef enum int {M_IDLE, M_PARSE, M_DONE} mphase_t;
   mphase_t     m_ph;
   bit          mq[$];
   int          m_cnt, m_n, m_used;
   logic [11:0] m_ns;
   logic        m_mode, m_err, m_done;

   task automatic model_reset();
      mq.delete();
      m_ph = M_IDLE; m_cnt = 0; m_n = 1; m_used = 0;
      m_ns = '0; m_mode = 1'b0; m_err = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_cycle();
      int sz, cons, nb;
      bit wv, bad, rdy;
      logic [127:0] w;
      logic [11:0] nsh;
      sz  = mq.size();
      nb  = int'(ecg_numbits);
      wv  = (m_ph == M_PARSE) && (sz >= 128);
      bad = wv && ((nb == 0) || (nb > sz));
      cons = (wv && !bad) ? nb : 0;
      rdy = (sz - cons) <= 224;
      for (int i = 0; i < 128; i++) w[127-i] = (i < sz) ? mq[i] : 1'b0;
      nsh = m_ns >> (3 * m_cnt);
      chk("win_valid", 128'(win_valid), 128'(wv));
      chk("win_data", win_data, w);
      chk("bs_ready", 128'(bs_ready), 128'(rdy));
      chk("win_ecg_idx", 128'(win_ecg_idx), 128'(m_cnt[1:0]));
      chk("win_num_sample", 128'(win_num_sample), 128'(nsh[2:0]));
      chk("win_mode_xfm", 128'(win_mode_xfm), 128'(m_mode));
      chk("ecg_done", 128'(ecg_done), 128'(m_done));
      chk("blk_done", 128'(blk_done), 128'(m_ph == M_DONE));
      chk("busy", 128'(busy), 128'(m_ph != M_IDLE));
      chk("err", 128'(err), 128'(m_err));
      chk("bits_used", 128'(bits_used), 128'(m_used[15:0]));
      chk("fill", 128'(dut.fill_q), 128'(sz));
      m_done = 1'b0;
      if (m_ph == M_PARSE) begin
         if (wv) begin
            if (bad) begin
               m_err = 1'b1;
               m_ph  = M_IDLE;
            end else begin
               repeat (cons) void'(mq.pop_front());
               m_used = (m_used + cons > 65535) ? 65535 : m_used + cons;
               m_done = 1'b1;
               if (m_cnt == m_n - 1) m_ph = M_DONE;
               else m_cnt++;
            end
         end
      end else if (m_ph == M_DONE) begin
         m_ph = M_IDLE;
      end else begin
         if (flush) mq.delete();
         if (start) begin
            m_n = (num_ecg == 0) ? 1 : ((num_ecg > 4) ? 4 : int'(num_ecg));
            m_ns = ns_cfg; m_mode = mode_xfm; m_err = 1'b0; m_used = 0; m_cnt = 0;
            m_ph = M_PARSE;
         end
      end
      if (bs_valid && rdy)
         for (int i = 31; i >= 0; i--) mq.push_back(bs_data[i]);
   endtask

   task automatic cyc(input logic st, input logic fl, input logic v, input logic [31:0] d,
                      input logic [7:0] b, input logic [2:0] ne, input logic [11:0] ns);
      start = st; flush = fl; bs_valid = v; bs_data = d;
      ecg_numbits = b; num_ecg = ne; ns_cfg = ns;
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic fl, st, v; logic [31:0] d; logic [7:0] nb; logic [2:0] ne; logic [11:0] ns;
      logic e_wv, e_done, e_blk, e_busy; logic [15:0] e_used; logic [1:0] e_idx;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] fresh;
      logic [31:0]  wds [4];
      // T1: four A5A5A5A5 words, one-ECG block of 20 bits
      for (int k = 0; k < 4; k++) tbl.push_back('{0,0,1,32'hA5A5A5A5,8'd0,3'd0,12'h0, 0,0,0,0,16'd0,2'd0});
      tbl.push_back('{0,1,0,32'h0,8'd0,3'd1,12'h0,   0,0,0,0,16'd0,2'd0});
      tbl.push_back('{0,0,0,32'h0,8'd20,3'd0,12'h0,  1,0,0,1,16'd0,2'd0});
      tbl.push_back('{0,0,0,32'h0,8'd0,3'd0,12'h0,   0,1,1,1,16'd20,2'd0});
      tbl.push_back('{0,0,0,32'h0,8'd0,3'd0,12'h0,   0,0,0,0,16'd20,2'd0});
      // T2: flush, fill to 256, four back-to-back 10-bit ECGs
      tbl.push_back('{1,0,0,32'h0,8'd0,3'd0,12'h0,   0,0,0,0,16'd20,2'd0});
      for (int k = 1; k <= 8; k++) tbl.push_back('{0,0,1,32'hC0DE0000 + 32'(k),8'd0,3'd0,12'h0, 0,0,0,0,16'd20,2'd0});
      tbl.push_back('{0,1,0,32'h0,8'd0,3'd4,12'h924, 0,0,0,0,16'd20,2'd0});
      tbl.push_back('{0,0,0,32'h0,8'd10,3'd0,12'h0,  1,0,0,1,16'd0,2'd0});
      tbl.push_back('{0,0,0,32'h0,8'd10,3'd0,12'h0,  1,1,0,1,16'd10,2'd1});
      tbl.push_back('{0,0,0,32'h0,8'd10,3'd0,12'h0,  1,1,0,1,16'd20,2'd2});
      tbl.push_back('{0,0,0,32'h0,8'd10,3'd0,12'h0,  1,1,0,1,16'd30,2'd3});
      tbl.push_back('{0,0,0,32'h0,8'd0,3'd0,12'h0,   0,1,1,1,16'd40,2'd3});
      tbl.push_back('{0,0,0,32'h0,8'd0,3'd0,12'h0,   0,0,0,0,16'd40,2'd3});

      rst = 1'b1; mode_xfm = 1'b0;
      start = 0; flush = 0; bs_valid = 0; bs_data = '0; ecg_numbits = '0; num_ecg = '0; ns_cfg = '0;
      model_reset();
      @(negedge clk);
      chk("rst_win_valid", 128'(win_valid), 128'(0));
      chk("rst_win_data", win_data, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'({ecg_done, blk_done, err}), 128'(0));
      chk("rst_outs", 128'({bits_used, win_ecg_idx, win_num_sample, win_mode_xfm}), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (tbl[i]) begin
         start = tbl[i].st; flush = tbl[i].fl; bs_valid = tbl[i].v; bs_data = tbl[i].d;
         ecg_numbits = tbl[i].nb; num_ecg = tbl[i].ne; ns_cfg = tbl[i].ns;
         @(negedge clk);
         chk($sformatf("tbl%0d_wv", i), 128'(win_valid), 128'(tbl[i].e_wv));
         chk($sformatf("tbl%0d_ecg_done", i), 128'(ecg_done), 128'(tbl[i].e_done));
         chk($sformatf("tbl%0d_blk_done", i), 128'(blk_done), 128'(tbl[i].e_blk));
         chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_used", i), 128'(bits_used), 128'(tbl[i].e_used));
         chk($sformatf("tbl%0d_idx", i), 128'(win_ecg_idx), 128'(tbl[i].e_idx));
         model_cycle();
         @(posedge clk); #1;
      end
      chk("t2_fill", 128'(dut.fill_q), 128'(216));

      // T3: fill=120 -> window waits for a push; then push+consume together
      cyc(0,1,0,0,0,0,0);
      for (int k = 0; k < 4; k++) cyc(0,0,1,32'h3C3C0000 + 32'(k),0,0,0);
      cyc(1,0,0,0,0,1,0);
      cyc(0,0,0,0,8,0,0);
      cyc(0,0,0,0,0,0,0);
      chk("t3_fill120", 128'(dut.fill_q), 128'(120));
      cyc(1,0,0,0,0,1,0);
      chk("t3_wait_wv", 128'(win_valid), 128'(0));
      cyc(0,0,0,0,9,0,0);
      chk("t3_still_wait", 128'(win_valid), 128'(0));
      cyc(0,0,1,32'h87654321,9,0,0);
      cyc(0,0,0,0,9,0,0);
      chk("t3_fill143", 128'(dut.fill_q), 128'(143));
      cyc(0,0,0,0,0,0,0);
      cyc(1,0,0,0,0,1,0);
      cyc(0,0,1,32'hFEEDBEEF,9,0,0);
      chk("t3_push_cons", 128'(dut.fill_q), 128'(166));
      cyc(0,0,0,0,0,0,0);

      // T4: zero numbits at fill=230 -> sticky err, no consume
      cyc(0,1,0,0,0,0,0);
      for (int k = 0; k < 8; k++) cyc(0,0,1,$urandom,0,0,0);
      cyc(1,0,0,0,0,1,0);
      cyc(0,0,0,0,26,0,0);
      cyc(0,0,0,0,0,0,0);
      chk("t4_fill230", 128'(dut.fill_q), 128'(230));
      cyc(1,0,0,0,0,1,0);
      cyc(0,0,0,0,0,0,0);
      chk("t4_err", 128'({err, busy, blk_done}), 128'(3'b100));
      chk("t4_fill_kept", 128'(dut.fill_q), 128'(230));
      cyc(1,0,0,0,0,1,0);
      chk("t4_err_clr", 128'(err), 128'(0));
      cyc(0,0,0,0,5,0,0);
      cyc(0,0,0,0,0,0,0);

      // T5: continuous valid while idle -> ready backs off, never overfills
      cyc(0,1,0,0,0,0,0);
      for (int k = 0; k < 10; k++) cyc(0,0,1,32'h10000001 * 32'(k + 1),0,0,0);
      chk("t5_full", 128'(dut.fill_q), 128'(256));
      chk("t5_ready_low", 128'(bs_ready), 128'(0));
      cyc(1,0,0,0,0,4,12'hFAC);
      for (int k = 0; k < 5; k++) cyc(0,0,0,0,32,0,0);

      // T6: reset mid-block after ECG1, then restart from fresh bits
      cyc(0,1,0,0,0,0,0);
      for (int k = 0; k < 8; k++) cyc(0,0,1,$urandom,0,0,0);
      mode_xfm = 1'b1;
      cyc(1,0,0,0,0,4,12'h5A3);
      mode_xfm = 1'b0;
      cyc(0,0,0,0,12,0,0);
      cyc(0,0,0,0,12,0,0);
      rst = 1'b1;
      #1;
      chk("t6_rst_flags", 128'({win_valid, ecg_done, blk_done, busy, err}), 128'(0));
      chk("t6_rst_outs", 128'({bits_used, win_ecg_idx, win_num_sample, win_mode_xfm}), 128'(0));
      chk("t6_rst_data", win_data, 128'(0));
      model_reset();
      start = 0; flush = 0; bs_valid = 0; ecg_numbits = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(0,1,0,0,0,0,0);
      for (int k = 0; k < 4; k++) begin
         wds[k] = 32'hF0F00001 + 32'(k * 3);
         cyc(0,0,1,wds[k],0,0,0);
      end
      fresh = {wds[0], wds[1], wds[2], wds[3]};
      cyc(1,0,0,0,0,1,0);
      ecg_numbits = 8'd16; start = 0; bs_valid = 0;
      @(negedge clk);
      chk("t6_fresh_win", win_data, fresh);
      model_cycle();
      @(posedge clk); #1;
      cyc(0,0,0,0,0,0,0);

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         logic st, fl, v;
         logic [7:0] b;
         int r;
         st = ($urandom % 6) == 0;
         fl = ($urandom % 20) == 0;
         v  = fl ? 1'b0 : (($urandom % 3) != 0);
         r  = $urandom % 25;
         b  = (r == 0) ? 8'd0 : ((r == 1) ? 8'hFF : 8'($urandom_range(1, 60)));
         mode_xfm = 1'($urandom);
         cyc(st, fl, v, $urandom, b, 3'($urandom_range(0, 4)), 12'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
